// File: rtl/tdoa_sad_if.sv
// ---------------------------------------------------------------------------
// tdoa_sad_if
// Bundles the frame input and the lag-result output of tdoa_sad_engine.
//   s_valid   frame strobe (one cycle per audio frame)
//   s_ready   engine accepts frames (FILL state)
//   s_data_a  reference channel of every pair, pair p at [p*DW +: DW]
//   s_data_b  delayed channel of every pair, same packing
//   cfg_hold  freeze pair rotation
//   busy      engine computing (CALC/DONE)
//   td_valid  one-cycle result strobe
//   td_lag    signed best lag in frames
//   td_pair   pair index of the result
//   td_sad    minimum sum of absolute differences
//   loud      loudness flag of the reference window
// master: frame source / result sink.  slave: the engine.
// ---------------------------------------------------------------------------
interface tdoa_sad_if #(
    parameter int DW     = 24,
    parameter int NPAIR  = 2,
    parameter int MAXLAG = 5,
    parameter int WIN    = 20
);
    localparam int LAGW = $clog2(MAXLAG + 1) + 1;
    localparam int PW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int SADW = DW + $clog2(WIN) + 1;

    logic                     s_valid;
    logic                     s_ready;
    logic [NPAIR*DW-1:0]      s_data_a;
    logic [NPAIR*DW-1:0]      s_data_b;
    logic                     cfg_hold;
    logic                     busy;
    logic                     td_valid;
    logic signed [LAGW-1:0]   td_lag;
    logic [PW-1:0]            td_pair;
    logic [SADW-1:0]          td_sad;
    logic                     loud;

    modport master (
        output s_valid, s_data_a, s_data_b, cfg_hold,
        input  s_ready, busy, td_valid, td_lag, td_pair, td_sad, loud
    );

    modport slave (
        input  s_valid, s_data_a, s_data_b, cfg_hold,
        output s_ready, busy, td_valid, td_lag, td_pair, td_sad, loud
    );
endinterface

// File: rtl/tdoa_sad_engine.sv
// ---------------------------------------------------------------------------
// tdoa_sad_engine
// Time-difference-of-arrival estimator for NPAIR multiplexed mic pairs.
// Buffers WIN+2*MAXLAG frames of the current pair, then searches lags
// -MAXLAG..+MAXLAG with one absolute difference per cycle and reports the
// lag of minimum SAD plus a loudness flag on the reference window.
// Ports:
//   clk  processing clock
//   rst  asynchronous, active-high reset
//   bus  tdoa_sad_if.slave (frame input, result output; see interface)
//
// state | meaning
// FILL  | accept frames of the current pair into the buffers
// CALC  | SAD search, one abs-diff per cycle
// DONE  | publish result, rotate pair
// ---------------------------------------------------------------------------
module tdoa_sad_engine #(
    parameter int DW       = 24,
    parameter int WIN      = 20,
    parameter int MAXLAG   = 5,
    parameter int NPAIR    = 2,
    parameter int THRES    = 16383,
    parameter int LOUD_MIN = 11
) (
    input  logic       clk,
    input  logic       rst,
    tdoa_sad_if.slave  bus
);
    localparam int L    = WIN + 2 * MAXLAG;
    localparam int NI   = 2 * MAXLAG + 1;
    localparam int KW   = $clog2(L);
    localparam int JW   = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int IW   = (NI > 1) ? $clog2(NI) : 1;
    localparam int CW   = $clog2(WIN + 1);
    localparam int LAGW = $clog2(MAXLAG + 1) + 1;
    localparam int PW   = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int SADW = DW + $clog2(WIN) + 1;

    typedef enum logic [1:0] {FILL, CALC, DONE} state_t;
    state_t state_q, state_d;

    logic [KW-1:0]          k_q;
    logic [JW-1:0]          j_q;
    logic [IW-1:0]          i_q;
    logic [IW-1:0]          best_q;
    logic [CW-1:0]          cnt_q;
    logic [SADW-1:0]        acc_q;
    logic [SADW-1:0]        min_q;
    logic [PW-1:0]          pair_q;
    logic                   td_valid_q;
    logic signed [LAGW-1:0] td_lag_q;
    logic [PW-1:0]          td_pair_q;
    logic [SADW-1:0]        td_sad_q;
    logic                   loud_q;

    logic [DW-1:0]          buf_a [L];
    logic [DW-1:0]          buf_b [L];

    logic [DW-1:0]          pair_a, pair_b;
    logic                   accept, last_frame, last_j, last_i;
    logic [KW-1:0]          addr_a, addr_b;
    logic [DW:0]            diff_w, abs_d;
    logic [SADW-1:0]        sum;

    always_comb begin
        pair_a = '0;
        pair_b = '0;
        for (int p = 0; p < NPAIR; p++) begin
            if (pair_q == PW'(p)) begin
                pair_a = bus.s_data_a[p*DW +: DW];
                pair_b = bus.s_data_b[p*DW +: DW];
            end
        end
    end

    assign accept     = bus.s_valid && (state_q == FILL);
    assign last_frame = accept && (k_q == KW'(L - 1));
    assign last_j     = (j_q == JW'(WIN - 1));
    assign last_i     = (i_q == IW'(NI - 1));

    // lag search: reference tap fixed at j+MAXLAG, delayed tap slides with i
    assign addr_a = KW'(j_q) + KW'(MAXLAG);
    assign addr_b = KW'(i_q) + KW'(j_q);
    assign diff_w = {1'b0, buf_a[addr_a]} - {1'b0, buf_b[addr_b]};
    assign abs_d  = diff_w[DW] ? (~diff_w + 1'b1) : diff_w;
    assign sum    = ((j_q == '0) ? '0 : acc_q) + SADW'(abs_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (last_frame) state_d = CALC;
            CALC:    if (last_j && last_i) state_d = DONE;
            DONE:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // buffers are fully rewritten each FILL, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_a[k_q] <= pair_a;
            buf_b[k_q] <= pair_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q        <= '0;
            j_q        <= '0;
            i_q        <= '0;
            best_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            min_q      <= '1;
            pair_q     <= '0;
            td_valid_q <= 1'b0;
            td_lag_q   <= '0;
            td_pair_q  <= '0;
            td_sad_q   <= '0;
            loud_q     <= 1'b0;
        end else begin
            td_valid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (k_q < KW'(WIN))
                            cnt_q <= ((k_q == '0) ? '0 : cnt_q) + CW'(pair_a > DW'(THRES));
                        if (last_frame) begin
                            k_q    <= '0;
                            j_q    <= '0;
                            i_q    <= '0;
                            best_q <= '0;
                            min_q  <= '1;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                CALC: begin
                    acc_q <= sum;
                    if (last_j) begin
                        j_q <= '0;
                        i_q <= i_q + IW'(1);
                        // strict compare: on ties the earlier (more negative) lag wins
                        if (sum < min_q) begin
                            min_q  <= sum;
                            best_q <= i_q;
                        end
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                DONE: begin
                    td_valid_q <= 1'b1;
                    td_lag_q   <= LAGW'(best_q) - LAGW'(MAXLAG);
                    td_sad_q   <= min_q;
                    td_pair_q  <= pair_q;
                    loud_q     <= (cnt_q >= CW'(LOUD_MIN));
                    if (!bus.cfg_hold)
                        pair_q <= (pair_q == PW'(NPAIR - 1)) ? '0 : pair_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready  = (state_q == FILL);
    assign bus.busy     = (state_q == CALC) || (state_q == DONE);
    assign bus.td_valid = td_valid_q;
    assign bus.td_lag   = td_lag_q;
    assign bus.td_pair  = td_pair_q;
    assign bus.td_sad   = td_sad_q;
    assign bus.loud     = loud_q;
endmodule

// File: tb/tb_tdoa_sad_engine.sv
module tb_tdoa_sad_engine;
    localparam int DW     = 24;
    localparam int WIN    = 20;
    localparam int MAXLAG = 5;
    localparam int NPAIR  = 2;
    localparam int L      = WIN + 2 * MAXLAG;
    localparam int LAT    = (2 * MAXLAG + 1) * WIN + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdoa_sad_if #(.DW(DW), .NPAIR(NPAIR), .MAXLAG(MAXLAG), .WIN(WIN)) bus ();

    tdoa_sad_engine #(
        .DW(DW), .WIN(WIN), .MAXLAG(MAXLAG), .NPAIR(NPAIR),
        .THRES(16383), .LOUD_MIN(11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] va0 [L];
    logic [DW-1:0] vb0 [L];
    logic [DW-1:0] va1 [L];
    logic [DW-1:0] vb1 [L];

    // ---------------- stimulus helpers ----------------
    task automatic ramp_pattern(input int base, input int off);
        for (int n = 0; n < L; n++) begin
            va0[n] = DW'(base + 100 * n);
            vb0[n] = (n >= 3) ? DW'(base + 100 * (n - 3) + off) : '0;
        end
    endtask

    task automatic const_pattern(input int v);
        for (int n = 0; n < L; n++) begin
            va0[n] = DW'(v);
            vb0[n] = DW'(v);
        end
    endtask

    task automatic copy_to_pair1();
        for (int n = 0; n < L; n++) begin
            va1[n] = va0[n];
            vb1[n] = vb0[n];
        end
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill_window();
        for (int k = 0; k < L; k++) begin
            bus.s_valid  = 1'b1;
            bus.s_data_a = {va1[k], va0[k]};
            bus.s_data_b = {vb1[k], vb0[k]};
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
    endtask

    // cycles from the accepting edge of the last frame to td_valid, -1 on timeout
    task automatic wait_result(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (bus.td_valid) begin
                lat = n;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst          = 1'b1;
        bus.s_valid  = 1'b0;
        bus.cfg_hold = 1'b0;
        bus.s_data_a = '0;
        bus.s_data_b = '0;
        #2;
        n_chk++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.td_valid !== 1'b0) begin n_fail++; $display("FAIL reset_td_valid: got %b expected 0", bus.td_valid); end
        n_chk++; if (bus.td_lag !== 4'sd0) begin n_fail++; $display("FAIL reset_td_lag: got %0d expected 0", bus.td_lag); end
        n_chk++; if (bus.td_pair !== 1'b0) begin n_fail++; $display("FAIL reset_td_pair: got %0d expected 0", bus.td_pair); end
        n_chk++; if (bus.td_sad !== 30'd0) begin n_fail++; $display("FAIL reset_td_sad: got %0d expected 0", bus.td_sad); end
        n_chk++; if (bus.loud !== 1'b0) begin n_fail++; $display("FAIL reset_loud: got %b expected 0", bus.loud); end
    endtask

    task automatic test_ramp();
        int lat; bit bok;
        apply_reset();
        ramp_pattern(0, 0);
        copy_to_pair1();
        fill_window();
        wait_result(lat, bok);
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL ramp_latency: got %0d expected %0d", lat, LAT); end
        n_chk++; if (bok !== 1'b1) begin n_fail++; $display("FAIL ramp_busy: got %b expected 1", bok); end
        n_chk++; if (bus.td_lag !== 4'sd3) begin n_fail++; $display("FAIL ramp_lag: got %0d expected 3", bus.td_lag); end
        n_chk++; if (bus.td_sad !== 30'd0) begin n_fail++; $display("FAIL ramp_sad: got %0d expected 0", bus.td_sad); end
        n_chk++; if (bus.td_pair !== 1'b0) begin n_fail++; $display("FAIL ramp_pair: got %0d expected 0", bus.td_pair); end
        n_chk++; if (bus.loud !== 1'b0) begin n_fail++; $display("FAIL ramp_loud: got %b expected 0", bus.loud); end
        @(posedge clk); #1;
        n_chk++; if (bus.td_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_strobe_width: got %b expected 0", bus.td_valid); end
        n_chk++; if (bus.td_lag !== 4'sd3) begin n_fail++; $display("FAIL ramp_lag_hold: got %0d expected 3", bus.td_lag); end
        n_chk++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_ready_after: got %b expected 1", bus.s_ready); end
    endtask

    task automatic test_const();
        int lat; bit bok;
        const_pattern(500);
        copy_to_pair1();
        fill_window();
        wait_result(lat, bok);
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL const_latency: got %0d expected %0d", lat, LAT); end
        n_chk++; if (bus.td_lag !== -4'sd5) begin n_fail++; $display("FAIL const_lag: got %0d expected -5", bus.td_lag); end
        n_chk++; if (bus.td_sad !== 30'd0) begin n_fail++; $display("FAIL const_sad: got %0d expected 0", bus.td_sad); end
        n_chk++; if (bus.td_pair !== 1'b1) begin n_fail++; $display("FAIL const_pair: got %0d expected 1", bus.td_pair); end
    endtask

    task automatic test_offset();
        int lat; bit bok;
        int offs [2] = '{7, -7};
        for (int t = 0; t < 2; t++) begin
            ramp_pattern(1000, offs[t]);
            copy_to_pair1();
            fill_window();
            wait_result(lat, bok);
            n_chk++; if (bus.td_lag !== 4'sd3) begin n_fail++; $display("FAIL offset_lag(%0d): got %0d expected 3", offs[t], bus.td_lag); end
            n_chk++; if (bus.td_sad !== 30'd140) begin n_fail++; $display("FAIL offset_sad(%0d): got %0d expected 140", offs[t], bus.td_sad); end
        end
    endtask

    task automatic test_loud();
        int lat; bit bok;
        bit exp_loud [3] = '{1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 3; c++) begin
            for (int n = 0; n < L; n++) begin
                case (c)
                    0: va0[n] = (n < 11) ? 24'd16384 : 24'd0;
                    1: va0[n] = (n < 10) ? 24'd16384 : (n < 20) ? 24'd16383 : 24'd16384;
                    default: va0[n] = ((n % 2 == 0 && n < 20) || n == 19) ? 24'd16384 : 24'd16383;
                endcase
                vb0[n] = va0[n];
            end
            copy_to_pair1();
            fill_window();
            wait_result(lat, bok);
            n_chk++; if (bus.loud !== exp_loud[c]) begin n_fail++; $display("FAIL loud_case%0d: got %b expected %b", c, bus.loud, exp_loud[c]); end
        end
    endtask

    task automatic test_pairs();
        int lat; bit bok;
        bit [0:0]        exp_pair [3] = '{1'b0, 1'b1, 1'b0};
        logic signed [3:0] exp_lag [3] = '{-4'sd5, 4'sd3, -4'sd5};
        apply_reset();
        bus.cfg_hold = 1'b0;
        const_pattern(500);
        for (int n = 0; n < L; n++) begin
            va1[n] = DW'(100 * n);
            vb1[n] = (n >= 3) ? DW'(100 * (n - 3)) : '0;
        end
        for (int w = 0; w < 3; w++) begin
            fill_window();
            wait_result(lat, bok);
            n_chk++; if (bus.td_pair !== exp_pair[w]) begin n_fail++; $display("FAIL pair_rot%0d: got %0d expected %0d", w, bus.td_pair, exp_pair[w]); end
            n_chk++; if (bus.td_lag !== exp_lag[w]) begin n_fail++; $display("FAIL pair_lag%0d: got %0d expected %0d", w, bus.td_lag, exp_lag[w]); end
        end
        apply_reset();
        bus.cfg_hold = 1'b1;
        fill_window();
        wait_result(lat, bok);
        n_chk++; if (bus.td_pair !== 1'b0) begin n_fail++; $display("FAIL hold_pair0: got %0d expected 0", bus.td_pair); end
        bus.cfg_hold = 1'b0;
        fill_window();
        wait_result(lat, bok);
        n_chk++; if (bus.td_pair !== 1'b0) begin n_fail++; $display("FAIL hold_pair1: got %0d expected 0", bus.td_pair); end
        n_chk++; if (bus.td_lag !== -4'sd5) begin n_fail++; $display("FAIL hold_lag: got %0d expected -5", bus.td_lag); end
    endtask

    task automatic test_drop();
        int lat; bit bok;
        int rdy_bad = 0;
        int chg_bad = 0;
        apply_reset();
        ramp_pattern(0, 0);
        copy_to_pair1();
        fill_window();
        bus.s_valid  = 1'b1;
        bus.s_data_a = {24'd777, 24'd777};
        bus.s_data_b = {24'd777, 24'd777};
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (bus.td_valid) begin
                lat = n;
                break;
            end
            if (bus.s_ready !== 1'b0) rdy_bad++;
            if (bus.td_lag !== 4'sd0 || bus.td_sad !== 30'd0) chg_bad++;
        end
        bus.s_valid = 1'b0;
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL drop_latency: got %0d expected %0d", lat, LAT); end
        n_chk++; if (rdy_bad != 0) begin n_fail++; $display("FAIL drop_ready: got %0d high cycles expected 0", rdy_bad); end
        n_chk++; if (chg_bad != 0) begin n_fail++; $display("FAIL drop_hold: got %0d changed cycles expected 0", chg_bad); end
        n_chk++; if (bus.td_lag !== 4'sd3) begin n_fail++; $display("FAIL drop_lag: got %0d expected 3", bus.td_lag); end
        const_pattern(500);
        copy_to_pair1();
        fill_window();
        wait_result(lat, bok);
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL drop_next_latency: got %0d expected %0d", lat, LAT); end
        n_chk++; if (bus.td_lag !== -4'sd5) begin n_fail++; $display("FAIL drop_next_lag: got %0d expected -5", bus.td_lag); end
        n_chk++; if (bus.td_sad !== 30'd0) begin n_fail++; $display("FAIL drop_next_sad: got %0d expected 0", bus.td_sad); end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok;
        int spur = 0;
        apply_reset();
        ramp_pattern(1000, 7);
        copy_to_pair1();
        fill_window();
        wait_result(lat, bok);
        n_chk++; if (bus.td_sad !== 30'd140) begin n_fail++; $display("FAIL mid_pre_sad: got %0d expected 140", bus.td_sad); end
        fill_window();
        repeat (100) @(posedge clk);
        #1;
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_chk++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_s_ready: got %b expected 1", bus.s_ready); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_clr: got %b expected 0", bus.busy); end
        n_chk++; if (bus.td_lag !== 4'sd0) begin n_fail++; $display("FAIL mid_td_lag: got %0d expected 0", bus.td_lag); end
        n_chk++; if (bus.td_sad !== 30'd0) begin n_fail++; $display("FAIL mid_td_sad: got %0d expected 0", bus.td_sad); end
        n_chk++; if (bus.td_valid !== 1'b0) begin n_fail++; $display("FAIL mid_td_valid: got %b expected 0", bus.td_valid); end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 250; n++) begin
            @(posedge clk);
            #1;
            if (bus.td_valid) spur++;
        end
        n_chk++; if (spur != 0) begin n_fail++; $display("FAIL mid_no_strobe: got %0d strobes expected 0", spur); end
        const_pattern(500);
        copy_to_pair1();
        fill_window();
        wait_result(lat, bok);
        n_chk++; if (lat != LAT) begin n_fail++; $display("FAIL mid_next_latency: got %0d expected %0d", lat, LAT); end
        n_chk++; if (bus.td_lag !== -4'sd5) begin n_fail++; $display("FAIL mid_next_lag: got %0d expected -5", bus.td_lag); end
        n_chk++; if (bus.td_pair !== 1'b0) begin n_fail++; $display("FAIL mid_next_pair: got %0d expected 0", bus.td_pair); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_const();
        test_offset();
        test_loud();
        test_pairs();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tdoa_sad_engine.md
TDOA_SAD_ENGINE -- requirements
Module: tdoa_sad_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DW 24: sample width, unsigned magnitude
- WIN 20: compared window length, frames
- MAXLAG 5: lag search range is -MAXLAG..+MAXLAG
- NPAIR 2: mic pairs multiplexed
- THRES 16383: loudness sample threshold
- LOUD_MIN 11: minimum samples above THRES for the loud flag
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  processing clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  frame strobe, one cycle per audio frame
- s_ready  out  1  high in FILL; low otherwise
- s_data_a  in  NPAIR*DW  reference channel of every pair; pair p at bits [p*DW +: DW]
- s_data_b  in  NPAIR*DW  delayed channel of every pair, same packing
- cfg_hold  in  1  freeze pair rotation
- busy  out  1  high in CALC/DONE
- td_valid  out  1  one-cycle result strobe
- td_lag  out  clog2(MAXLAG+1)+1  signed lag, frames
- td_pair  out  clog2(NPAIR) (min 1)  pair index of the result
- td_sad  out  DW+clog2(WIN)+1  minimum SAD
- loud  out  1  loudness flag, updated with td_valid

Function
REQ-003 Single clk domain; all state changes on rising clk; rst is the only asynchronous input.
REQ-004 States: FILL, CALC, DONE; FILL after reset.
REQ-005 FILL: each s_valid with s_ready stores the selected pair's A and B words at index k; k counts 0..L-1, L=WIN+2*MAXLAG.
REQ-006 FILL: acceptance of frame k=L-1 moves to CALC next cycle; k clears.
REQ-007 CALC: one abs-diff per cycle, |A[j+MAXLAG]-B[i+j]|; j inner 0..WIN-1, i outer 0..2*MAXLAG.
REQ-008 Accumulator width DW+clog2(WIN)+1; never saturates or wraps; abs-diff computed at DW+1 bits.
REQ-009 At j=WIN-1, final sum compared to running minimum (initialised all-ones); strictly-less updates min and best_i; ties keep the smaller i.
REQ-010 After i=2*MAXLAG, j=WIN-1: go to DONE.
REQ-011 DONE lasts one cycle: td_valid=1; td_lag=best_i-MAXLAG; td_sad=min; td_pair=current pair; loud updated; then FILL.
REQ-012 Latency: td_valid high exactly (2*MAXLAG+1)*WIN+1 cycles after the accepting edge of frame L-1 (221 at defaults).
REQ-013 loud=1 iff count of A[0..WIN-1] strictly greater than THRES is >= LOUD_MIN; counted during FILL, no extra cycles.
REQ-014 s_valid during CALC/DONE: frame dropped; no state change; no error.
REQ-015 Pair rotation in DONE: pair=(pair+1) mod NPAIR unless cfg_hold=1; NPAIR=1 always pair 0.
REQ-016 cfg_hold is sampled only in DONE; pair is stable for a whole FILL/CALC.
REQ-017 td_lag, td_sad, td_pair and loud hold their values between td_valid strobes.

Reset
REQ-018 rst=1, any state, any cycle: immediately FILL, k=0, pair=0.
- outputs: s_ready=1, busy=0, td_valid=0, td_lag=0, td_pair=0, td_sad=0, loud=0; min all-ones
REQ-019 Buffer contents are not reset; they are fully rewritten before the next CALC.
REQ-020 Release of rst: first s_valid accepted on the first rising clk with rst low.

Verification (defaults unless noted)
REQ-021 Ramp A[n]=100*n, B[n]=A[n-3] on pair 0 -> td_lag=+3, td_sad=0, td_pair=0, td_valid 221 cycles after frame 29.
REQ-022 A=B=constant 500 -> all SADs 0 -> tie rule gives td_lag=-5, td_sad=0.
REQ-023 11 of first 20 A samples =16384, rest 0 -> loud=1; only 10 such samples -> loud=0; samples =16383 never count.
REQ-024 Two windows, cfg_hold=0 -> td_pair 0 then 1, third window 0; cfg_hold=1 at first DONE -> td_pair 0,0.
REQ-025 s_valid pulsed every cycle during CALC -> s_ready=0, results unchanged, next window starts from first frame after DONE.
REQ-026 rst asserted at CALC cycle 100 -> all outputs zero the same cycle, no td_valid, next full window produces a correct result.
